// File: rtl/icache_ro_if.sv
// Bus bundles for the read-only instruction cache: fetch-side request port
// and 128-bit block memory port.

interface icache_ro_if;
    logic        proc_read;
    logic        proc_write;
    logic [29:0] proc_addr;
    logic [31:0] proc_wdata;
    logic [31:0] proc_rdata;
    logic        proc_stall;

    // Fetch stage drives the request; the cache answers with data/stall.
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_rdata, proc_stall
    );
    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_rdata, proc_stall
    );
endinterface

interface icache_mem_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    // mem_read/mem_addr stay stable until the one-cycle mem_ready pulse.
    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );
    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache: combinational hits, one 4-word
// block refill per miss through a two-state IDLE/ALLOC controller.

module icache_ro #(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_W    = $clog2(NUM_BLOCKS),
    parameter int TAG_W      = 28 - INDEX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    icache_ro_if.slave  proc,
    icache_mem_if.master mem,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic        dbg_state
);

    typedef enum logic {IDLE = 1'b0, ALLOC = 1'b1} state_e;

    state_e state, state_nxt;

    logic [NUM_BLOCKS-1:0] valid_arr;
    logic [TAG_W-1:0]      tag_arr  [NUM_BLOCKS];
    logic [127:0]          data_arr [NUM_BLOCKS];

    logic [27:0]        miss_addr;
    logic               mem_read_q, mem_read_nxt;
    logic               miss_latch, fill, hit_inc, miss_inc;

    logic [1:0]         req_offset;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] miss_index;
    logic [TAG_W-1:0]   miss_tag;
    logic [127:0]       req_line;
    logic               hit;

    // Writes are not supported; these inputs are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = proc.proc_write ^ (^proc.proc_wdata);

    assign req_offset = proc.proc_addr[1:0];
    assign req_index  = proc.proc_addr[INDEX_W+1:2];
    assign req_tag    = proc.proc_addr[29:INDEX_W+2];
    assign miss_index = miss_addr[INDEX_W-1:0];
    assign miss_tag   = miss_addr[27:INDEX_W];

    assign req_line = data_arr[req_index];
    assign hit      = proc.proc_read & valid_arr[req_index]
                      & (tag_arr[req_index] == req_tag);

    always_comb begin
        proc.proc_rdata = req_line[31:0];
        case (req_offset)
            2'd0: proc.proc_rdata = req_line[31:0];
            2'd1: proc.proc_rdata = req_line[63:32];
            2'd2: proc.proc_rdata = req_line[95:64];
            2'd3: proc.proc_rdata = req_line[127:96];
            default: proc.proc_rdata = req_line[31:0];
        endcase
    end

    assign proc.proc_stall = proc.proc_read & ~hit;

    assign mem.mem_read  = mem_read_q;
    assign mem.mem_addr  = miss_addr;
    assign mem.mem_write = 1'b0;
    assign mem.mem_wdata = '0;
    assign dbg_state     = (state == ALLOC);

    always_comb begin
        state_nxt    = state;
        mem_read_nxt = mem_read_q;
        miss_latch   = 1'b0;
        fill         = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (proc.proc_read && !hit) begin
                    state_nxt    = ALLOC;
                    mem_read_nxt = 1'b1;
                    miss_latch   = 1'b1;
                    miss_inc     = 1'b1;
                end else if (hit) begin
                    hit_inc = 1'b1;
                end
            end
            ALLOC: begin
                // The fill always lands at the latched miss address, even if
                // the requester has moved on.
                if (mem.mem_ready) begin
                    fill         = 1'b1;
                    state_nxt    = IDLE;
                    mem_read_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                mem_read_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_read_q <= 1'b0;
            miss_addr  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            mem_read_q <= mem_read_nxt;
            if (miss_latch) miss_addr <= proc.proc_addr[29:2];
            if (hit_inc)    hit_cnt   <= hit_cnt + 32'd1;
            if (miss_inc)   miss_cnt  <= miss_cnt + 32'd1;
        end
    end

    // Arrays are cleared on reset so the read mux never presents X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_arr <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_arr[i]  <= '0;
                data_arr[i] <= '0;
            end
        end else if (fill) begin
            valid_arr[miss_index] <= 1'b1;
            tag_arr[miss_index]   <= miss_tag;
            data_arr[miss_index]  <= mem.mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_ro.sv
// Directed bench for icache_ro: miss/refill, sequential hits, conflict
// eviction, address change during refill, async reset mid-refill, writes.

module tb_icache_ro;

  logic clk;
  logic rst_n;
  logic [31:0] hit_cnt, miss_cnt;
  logic dbg_state;

  icache_ro_if  pif ();
  icache_mem_if mif ();

  icache_ro dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .proc      (pif),
    .mem       (mif),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] D1 = 128'h44443333_22221111_00000013_DEADBEEF;
  localparam logic [127:0] D2 = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
  localparam logic [127:0] D3 = 128'h30000003_30000002_30000001_30000000;
  localparam logic [127:0] D4 = 128'h40000003_40000002_40000001_40000000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    pif.proc_read = 1'b0; pif.proc_write = 1'b0;
    pif.proc_addr = '0;   pif.proc_wdata = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    @(negedge clk); #1;
    n_vec++; if (pif.proc_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %h exp 0", pif.proc_stall); end
    n_vec++; if (mif.mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read got %h exp 0", mif.mem_read); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state got %h exp 0", dbg_state); end
    n_vec++; if (hit_cnt !== 32'd0) begin n_err++; $display("FAIL rst_hit_cnt got %h exp 0", hit_cnt); end
    n_vec++; if (miss_cnt !== 32'd0) begin n_err++; $display("FAIL rst_miss_cnt got %h exp 0", miss_cnt); end
    n_vec++; if (pif.proc_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %h exp 0", pif.proc_rdata); end
    n_vec++; if (mif.mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write got %h exp 0", mif.mem_write); end
    n_vec++; if (mif.mem_wdata !== 128'd0) begin n_err++; $display("FAIL rst_mem_wdata got %h exp 0", mif.mem_wdata); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL post_rst_state got %h exp 0", dbg_state); end
  endtask

  task automatic test_miss_fill;
    @(negedge clk); pif.proc_read = 1'b1; pif.proc_addr = 30'h4; #1;
    n_vec++; if (pif.proc_stall !== 1'b1) begin n_err++; $display("FAIL miss_stall got %h exp 1", pif.proc_stall); end
    n_vec++; if (mif.mem_read !== 1'b0) begin n_err++; $display("FAIL miss_idle_mem_read got %h exp 0", mif.mem_read); end
    @(negedge clk); #1;
    n_vec++; if (mif.mem_read !== 1'b1) begin n_err++; $display("FAIL alloc_mem_read got %h exp 1", mif.mem_read); end
    n_vec++; if (mif.mem_addr !== 28'h1) begin n_err++; $display("FAIL alloc_mem_addr got %h exp 1", mif.mem_addr); end
    n_vec++; if (dbg_state !== 1'b1) begin n_err++; $display("FAIL alloc_state got %h exp 1", dbg_state); end
    n_vec++; if (miss_cnt !== 32'd1) begin n_err++; $display("FAIL miss_cnt1 got %h exp 1", miss_cnt); end
    n_vec++; if (pif.proc_stall !== 1'b1) begin n_err++; $display("FAIL alloc_stall got %h exp 1", pif.proc_stall); end
    repeat (4) @(negedge clk);
    #1;
    n_vec++; if (mif.mem_addr !== 28'h1) begin n_err++; $display("FAIL alloc_hold_addr got %h exp 1", mif.mem_addr); end
    mif.mem_ready = 1'b1; mif.mem_rdata = D1;
    @(negedge clk); mif.mem_ready = 1'b0; #1;
    n_vec++; if (pif.proc_stall !== 1'b0) begin n_err++; $display("FAIL refill_stall got %h exp 0", pif.proc_stall); end
    n_vec++; if (pif.proc_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL refill_rdata got %h exp deadbeef", pif.proc_rdata); end
    n_vec++; if (mif.mem_read !== 1'b0) begin n_err++; $display("FAIL refill_mem_read got %h exp 0", mif.mem_read); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL refill_state got %h exp 0", dbg_state); end
    n_vec++; if (hit_cnt !== 32'd0) begin n_err++; $display("FAIL refill_hit_cnt got %h exp 0", hit_cnt); end
  endtask

  task automatic test_seq_hits;
    logic [31:0] seq_exp [4];
    seq_exp = '{32'hDEADBEEF, 32'h00000013, 32'h22221111, 32'h44443333};
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); pif.proc_addr = 30'h4 + 30'(i); #1;
      n_vec++; if (pif.proc_stall !== 1'b0) begin n_err++; $display("FAIL seq_stall[%0d] got %h exp 0", i, pif.proc_stall); end
      n_vec++; if (pif.proc_rdata !== seq_exp[i]) begin n_err++; $display("FAIL seq_rdata[%0d] got %h exp %h", i, pif.proc_rdata, seq_exp[i]); end
    end
    @(negedge clk); pif.proc_read = 1'b0; #1;
    n_vec++; if (hit_cnt !== 32'd4) begin n_err++; $display("FAIL seq_hit_cnt got %h exp 4", hit_cnt); end
    n_vec++; if (miss_cnt !== 32'd1) begin n_err++; $display("FAIL seq_miss_cnt got %h exp 1", miss_cnt); end
    n_vec++; if (pif.proc_stall !== 1'b0) begin n_err++; $display("FAIL idle_stall got %h exp 0", pif.proc_stall); end
  endtask

  task automatic test_conflict;
    // 0x24 shares index 1 with 0x4 but carries tag 1.
    @(negedge clk); pif.proc_read = 1'b1; pif.proc_addr = 30'h24; #1;
    n_vec++; if (pif.proc_stall !== 1'b1) begin n_err++; $display("FAIL conf_stall got %h exp 1", pif.proc_stall); end
    @(negedge clk); #1;
    n_vec++; if (mif.mem_addr !== 28'h9) begin n_err++; $display("FAIL conf_mem_addr got %h exp 9", mif.mem_addr); end
    n_vec++; if (miss_cnt !== 32'd2) begin n_err++; $display("FAIL conf_miss_cnt got %h exp 2", miss_cnt); end
    mif.mem_ready = 1'b1; mif.mem_rdata = D2;
    @(negedge clk); mif.mem_ready = 1'b0; #1;
    n_vec++; if (pif.proc_rdata !== 32'hA0A0A0A0) begin n_err++; $display("FAIL conf_rdata got %h exp a0a0a0a0", pif.proc_rdata); end
    n_vec++; if (pif.proc_stall !== 1'b0) begin n_err++; $display("FAIL conf_hit_stall got %h exp 0", pif.proc_stall); end
    @(negedge clk); pif.proc_addr = 30'h4; #1;
    n_vec++; if (pif.proc_stall !== 1'b1) begin n_err++; $display("FAIL evict_stall got %h exp 1", pif.proc_stall); end
    n_vec++; if (hit_cnt !== 32'd5) begin n_err++; $display("FAIL conf_hit_cnt got %h exp 5", hit_cnt); end
    @(negedge clk); #1;
    n_vec++; if (mif.mem_addr !== 28'h1) begin n_err++; $display("FAIL evict_mem_addr got %h exp 1", mif.mem_addr); end
    n_vec++; if (miss_cnt !== 32'd3) begin n_err++; $display("FAIL evict_miss_cnt got %h exp 3", miss_cnt); end
    mif.mem_ready = 1'b1; mif.mem_rdata = D1;
    @(negedge clk); mif.mem_ready = 1'b0; #1;
    n_vec++; if (pif.proc_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL evict_rdata got %h exp deadbeef", pif.proc_rdata); end
    @(negedge clk); pif.proc_read = 1'b0; #1;
    n_vec++; if (hit_cnt !== 32'd6) begin n_err++; $display("FAIL conf_end_hit_cnt got %h exp 6", hit_cnt); end
  endtask

  task automatic test_addr_change;
    @(negedge clk); pif.proc_read = 1'b1; pif.proc_addr = 30'h40; #1;
    n_vec++; if (pif.proc_stall !== 1'b1) begin n_err++; $display("FAIL chg_stall got %h exp 1", pif.proc_stall); end
    @(negedge clk); #1;
    n_vec++; if (mif.mem_addr !== 28'h10) begin n_err++; $display("FAIL chg_mem_addr got %h exp 10", mif.mem_addr); end
    n_vec++; if (miss_cnt !== 32'd4) begin n_err++; $display("FAIL chg_miss_cnt got %h exp 4", miss_cnt); end
    pif.proc_addr = 30'h100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_vec++; if (mif.mem_addr !== 28'h10) begin n_err++; $display("FAIL chg_hold_addr[%0d] got %h exp 10", i, mif.mem_addr); end
      n_vec++; if (mif.mem_read !== 1'b1) begin n_err++; $display("FAIL chg_hold_read[%0d] got %h exp 1", i, mif.mem_read); end
    end
    mif.mem_ready = 1'b1; mif.mem_rdata = D3;
    @(negedge clk); mif.mem_ready = 1'b0; #1;
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL chg_idle_state got %h exp 0", dbg_state); end
    n_vec++; if (pif.proc_stall !== 1'b1) begin n_err++; $display("FAIL chg_new_stall got %h exp 1", pif.proc_stall); end
    n_vec++; if (miss_cnt !== 32'd4) begin n_err++; $display("FAIL chg_miss_cnt4 got %h exp 4", miss_cnt); end
    @(negedge clk); #1;
    n_vec++; if (mif.mem_addr !== 28'h40) begin n_err++; $display("FAIL chg_new_mem_addr got %h exp 40", mif.mem_addr); end
    n_vec++; if (miss_cnt !== 32'd5) begin n_err++; $display("FAIL chg_miss_cnt5 got %h exp 5", miss_cnt); end
    // The line filled for 0x40 must now hit, even while the next fill is out.
    pif.proc_addr = 30'h41; #1;
    n_vec++; if (pif.proc_stall !== 1'b0) begin n_err++; $display("FAIL chg_old_line_stall got %h exp 0", pif.proc_stall); end
    n_vec++; if (pif.proc_rdata !== 32'h30000001) begin n_err++; $display("FAIL chg_old_line_rdata got %h exp 30000001", pif.proc_rdata); end
    pif.proc_addr = 30'h100; mif.mem_ready = 1'b1; mif.mem_rdata = D4;
    @(negedge clk); mif.mem_ready = 1'b0; #1;
    n_vec++; if (pif.proc_rdata !== 32'h40000000) begin n_err++; $display("FAIL chg_new_rdata got %h exp 40000000", pif.proc_rdata); end
    @(negedge clk); pif.proc_read = 1'b0; #1;
    n_vec++; if (hit_cnt !== 32'd7) begin n_err++; $display("FAIL chg_hit_cnt got %h exp 7", hit_cnt); end
  endtask

  task automatic test_reset_mid_alloc;
    @(negedge clk); pif.proc_read = 1'b1; pif.proc_addr = 30'h48;
    @(negedge clk); #1;
    n_vec++; if (mif.mem_addr !== 28'h12) begin n_err++; $display("FAIL ra_mem_addr got %h exp 12", mif.mem_addr); end
    #2 rst_n = 1'b0; #1;
    n_vec++; if (mif.mem_read !== 1'b0) begin n_err++; $display("FAIL ra_mem_read got %h exp 0", mif.mem_read); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL ra_state got %h exp 0", dbg_state); end
    n_vec++; if (miss_cnt !== 32'd0) begin n_err++; $display("FAIL ra_miss_cnt got %h exp 0", miss_cnt); end
    n_vec++; if (hit_cnt !== 32'd0) begin n_err++; $display("FAIL ra_hit_cnt got %h exp 0", hit_cnt); end
    @(negedge clk); pif.proc_read = 1'b0; rst_n = 1'b1;
    @(negedge clk); mif.mem_ready = 1'b1; mif.mem_rdata = D3;
    @(negedge clk); mif.mem_ready = 1'b0; #1;
    n_vec++; if (mif.mem_read !== 1'b0) begin n_err++; $display("FAIL stray_mem_read got %h exp 0", mif.mem_read); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL stray_state got %h exp 0", dbg_state); end
    @(negedge clk); pif.proc_read = 1'b1; pif.proc_addr = 30'h4; #1;
    n_vec++; if (pif.proc_stall !== 1'b1) begin n_err++; $display("FAIL ra_reread_stall got %h exp 1", pif.proc_stall); end
    n_vec++; if (pif.proc_rdata !== 32'd0) begin n_err++; $display("FAIL ra_cleared_rdata got %h exp 0", pif.proc_rdata); end
    @(negedge clk); #1;
    n_vec++; if (mif.mem_addr !== 28'h1) begin n_err++; $display("FAIL ra_reread_addr got %h exp 1", mif.mem_addr); end
    n_vec++; if (miss_cnt !== 32'd1) begin n_err++; $display("FAIL ra_reread_miss_cnt got %h exp 1", miss_cnt); end
    mif.mem_ready = 1'b1; mif.mem_rdata = D1;
    @(negedge clk); mif.mem_ready = 1'b0; pif.proc_read = 1'b0; #1;
    n_vec++; if (pif.proc_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL ra_refill_rdata got %h exp deadbeef", pif.proc_rdata); end
  endtask

  task automatic test_write_only;
    @(negedge clk);
    pif.proc_read = 1'b0; pif.proc_write = 1'b1;
    pif.proc_addr = 30'h80; pif.proc_wdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (pif.proc_stall !== 1'b0) begin n_err++; $display("FAIL wr_stall[%0d] got %h exp 0", i, pif.proc_stall); end
      n_vec++; if (mif.mem_read !== 1'b0) begin n_err++; $display("FAIL wr_mem_read[%0d] got %h exp 0", i, mif.mem_read); end
      @(negedge clk);
    end
    #1;
    n_vec++; if (hit_cnt !== 32'd0) begin n_err++; $display("FAIL wr_hit_cnt got %h exp 0", hit_cnt); end
    n_vec++; if (miss_cnt !== 32'd1) begin n_err++; $display("FAIL wr_miss_cnt got %h exp 1", miss_cnt); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL wr_state got %h exp 0", dbg_state); end
    pif.proc_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_seq_hits();
    test_conflict();
    test_addr_change();
    test_reset_mid_alloc();
    test_write_only();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
